// File: rtl/rr_interval_extractor_if.sv
// Sample stream into the R-peak extractor and beat/timeout reports back out.
// The extractor takes the slave side; the sample source takes the master side.
interface rr_interval_extractor_if #(
  parameter int DATA_W = 12
);
  logic                     sample_en;
  logic signed [DATA_W-1:0] ecg_sample;
  logic                     r_peak;
  logic [15:0]              rr_value;
  logic                     peak_timeout;

  modport master (
    output sample_en, ecg_sample,
    input  r_peak, rr_value, peak_timeout
  );

  modport slave (
    input  sample_en, ecg_sample,
    output r_peak, rr_value, peak_timeout
  );
endinterface

// File: rtl/rr_interval_extractor.sv
// R-peak detector: slope energy against an adaptive threshold, refractory blanking,
// no-beat timeout with threshold search-back, and beat-to-beat interval reporting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | waiting for slope energy to exceed the threshold
// TRACK   | following a candidate peak until it decays or times out
// REFRACT | blanking after a confirmed peak; detection input ignored
module rr_interval_extractor #(
  parameter int DATA_W      = 12,
  parameter int REFRACTORY  = 20,
  parameter int MAX_TRACK   = 10,
  parameter int RR_TIMEOUT  = 300,
  parameter int INIT_THRESH = 64,
  parameter int MIN_THRESH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_interval_extractor_if.slave bus
);

  localparam int TRK_W = $clog2(MAX_TRACK + 1);
  localparam int RC_W  = $clog2(REFRACTORY + 1);
  localparam logic [TRK_W-1:0] TRK_MAX   = TRK_W'(MAX_TRACK);
  localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(REFRACTORY);
  localparam logic [15:0]      TOUT_LD   = 16'(RR_TIMEOUT);
  localparam logic [15:0]      THR_INIT  = 16'(INIT_THRESH);
  localparam logic [15:0]      SPK_INIT  = 16'(2 * INIT_THRESH);
  localparam logic [15:0]      THR_FLOOR = 16'(MIN_THRESH);

  typedef enum logic [1:0] {SEARCH, TRACK, REFRACT} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x1_q, x2_q;
  logic [DATA_W-1:0]        pk_q, pk_d, pk_eff;
  logic [TRK_W-1:0]         trk_q, trk_d;
  logic [RC_W-1:0]          rcnt_q, rcnt_d;
  logic [15:0]              spk_q, thresh_q, since_q, tout_q;
  logic                     armed_q, r_peak_q, to_q;
  logic [15:0]              rr_q;

  logic signed [DATA_W:0] d;
  logic [DATA_W:0]        d_abs;
  logic [DATA_W-1:0]      e;
  logic                   confirm, since_sat, tout_hit, timeout;
  logic [15:0]            spk_new, thr_conf, thr_half;

  // Slope energy; |d| only exceeds DATA_W bits when d is the most negative value.
  always_comb begin
    d     = {bus.ecg_sample[DATA_W-1], bus.ecg_sample} - {x2_q[DATA_W-1], x2_q};
    d_abs = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    e     = d_abs[DATA_W] ? {DATA_W{1'b1}} : d_abs[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    pk_d    = pk_q;
    trk_d   = trk_q;
    rcnt_d  = rcnt_q;
    pk_eff  = pk_q;
    confirm = 1'b0;
    case (state_q)
      SEARCH: begin
        if (16'(e) > thresh_q) begin
          state_d = TRACK;
          pk_d    = e;
          trk_d   = TRK_W'(1);
        end
      end
      TRACK: begin
        if (e >= pk_q) pk_eff = e;
        pk_d = pk_eff;
        if ((e < (pk_q >> 1)) || (trk_q == TRK_MAX)) confirm = 1'b1;
        else trk_d = trk_q + TRK_W'(1);
      end
      REFRACT: begin
        if (rcnt_q == RC_MAX) state_d = SEARCH;
        else rcnt_d = rcnt_q + RC_W'(1);
      end
      default: state_d = SEARCH;
    endcase
    if (confirm) begin
      state_d = REFRACT;
      rcnt_d  = RC_W'(1);
    end
  end

  // tout_q tracks the distance to the next multiple of RR_TIMEOUT in since_q,
  // frozen together with since_q once the interval counter saturates.
  always_comb begin
    since_sat = (since_q == 16'hFFFF);
    tout_hit  = !since_sat && (tout_q == 16'd1);
    timeout   = tout_hit && (state_q != REFRACT) && !confirm;
    spk_new   = spk_q - (spk_q >> 3) + 16'(pk_eff >> 3);
    thr_conf  = ((spk_new >> 1) > THR_FLOOR) ? (spk_new >> 1) : THR_FLOOR;
    thr_half  = ((thresh_q >> 1) > THR_FLOOR) ? (thresh_q >> 1) : THR_FLOOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      x1_q     <= '0;
      x2_q     <= '0;
      pk_q     <= '0;
      trk_q    <= '0;
      rcnt_q   <= '0;
      spk_q    <= SPK_INIT;
      thresh_q <= THR_INIT;
      since_q  <= '0;
      tout_q   <= TOUT_LD;
      armed_q  <= 1'b0;
      r_peak_q <= 1'b0;
      to_q     <= 1'b0;
      rr_q     <= '0;
    end else if (bus.sample_en) begin
      state_q  <= state_d;
      x2_q     <= x1_q;
      x1_q     <= bus.ecg_sample;
      pk_q     <= pk_d;
      trk_q    <= trk_d;
      rcnt_q   <= rcnt_d;
      r_peak_q <= confirm && armed_q;
      to_q     <= timeout;
      if (confirm) begin
        since_q  <= 16'd1;
        tout_q   <= TOUT_LD - 16'd1;
        spk_q    <= spk_new;
        thresh_q <= thr_conf;
        armed_q  <= 1'b1;
        if (armed_q) rr_q <= since_q;
      end else begin
        if (!since_sat) begin
          since_q <= since_q + 16'd1;
          tout_q  <= tout_hit ? TOUT_LD : tout_q - 16'd1;
        end
        if (timeout) thresh_q <= thr_half;
      end
    end
  end

  assign bus.r_peak       = r_peak_q;
  assign bus.rr_value     = rr_q;
  assign bus.peak_timeout = to_q;

endmodule

// File: tb/tb_rr_interval_extractor.sv
// Directed bench for rr_interval_extractor: one task per scenario, each sample is
// one sample_en clock followed by one idle clock; outputs sampled on negedge.
module tb_rr_interval_extractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic signed [11:0] stim[$];
  int pk_idx[$];
  int pk_rr[$];
  int to_idx[$];

  always #5 clk = ~clk;

  rr_interval_extractor_if #(.DATA_W(12)) bus ();

  rr_interval_extractor #(.DATA_W(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.sample_en  = 1'b0;
    bus.ecg_sample = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic smp(input logic signed [11:0] v);
    @(negedge clk);
    bus.sample_en  = 1'b1;
    bus.ecg_sample = v;
    @(negedge clk);
    bus.sample_en  = 1'b0;
  endtask

  task automatic fill(input int n, input logic signed [11:0] v);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(v);
  endtask

  task automatic play();
    pk_idx.delete();
    pk_rr.delete();
    to_idx.delete();
    for (int i = 0; i < stim.size(); i++) begin
      smp(stim[i]);
      if (bus.r_peak === 1'b1) begin
        pk_idx.push_back(i + 1);
        pk_rr.push_back(int'(bus.rr_value));
      end
      if (bus.peak_timeout === 1'b1) to_idx.push_back(i + 1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.r_peak !== 1'b0) begin errors++; $display("FAIL reset_r_peak: got %0d expected 0", bus.r_peak); end
    checks++; if (bus.rr_value !== 16'd0) begin errors++; $display("FAIL reset_rr_value: got %0d expected 0", bus.rr_value); end
    checks++; if (bus.peak_timeout !== 1'b0) begin errors++; $display("FAIL reset_peak_timeout: got %0d expected 0", bus.peak_timeout); end
    checks++; if (dut.thresh_q !== 16'd64) begin errors++; $display("FAIL reset_thresh: got %0d expected 64", dut.thresh_q); end
    checks++; if (dut.spk_q !== 16'd128) begin errors++; $display("FAIL reset_spk: got %0d expected 128", dut.spk_q); end
  endtask

  task automatic test_timeout();
    int got;
    do_reset();
    fill(300, 12'sd0);
    play();
    got = (to_idx.size() > 0) ? to_idx[0] : -1;
    checks++; if (pk_idx.size() != 0) begin errors++; $display("FAIL flat_no_peak: got %0d pulses expected 0", pk_idx.size()); end
    checks++; if (to_idx.size() != 1 || got != 300) begin errors++; $display("FAIL flat_timeout_at: got %0d pulses first at %0d expected 1 at 300", to_idx.size(), got); end
    checks++; if (dut.thresh_q !== 16'd32) begin errors++; $display("FAIL flat_thresh_halved: got %0d expected 32", dut.thresh_q); end
    bus.ecg_sample = 12'sd1000;
    repeat (50) @(negedge clk);
    checks++; if (bus.peak_timeout !== 1'b1) begin errors++; $display("FAIL hold_peak_timeout: got %0d expected 1", bus.peak_timeout); end
    checks++; if (dut.since_q !== 16'd300) begin errors++; $display("FAIL hold_since_last: got %0d expected 300", dut.since_q); end
    fill(100, 12'sd0);
    play();
    checks++; if (to_idx.size() != 0 || pk_idx.size() != 0) begin errors++; $display("FAIL flat_tail_events: got %0d timeouts %0d peaks expected 0 0", to_idx.size(), pk_idx.size()); end
    checks++; if (bus.peak_timeout !== 1'b0) begin errors++; $display("FAIL flat_timeout_cleared: got %0d expected 0", bus.peak_timeout); end
    checks++; if (dut.since_q !== 16'd400) begin errors++; $display("FAIL flat_since_last: got %0d expected 400", dut.since_q); end
  endtask

  task automatic test_spikes();
    int gi, gr;
    do_reset();
    fill(300, 12'sd0);
    stim[9] = 12'sd800; stim[89] = 12'sd800; stim[169] = 12'sd800; stim[249] = 12'sd800;
    play();
    checks++; if (pk_idx.size() != 3) begin errors++; $display("FAIL spikes_count: got %0d expected 3", pk_idx.size()); end
    for (int k = 0; k < 3; k++) begin
      gi = (k < pk_idx.size()) ? pk_idx[k] : -1;
      gr = (k < pk_rr.size()) ? pk_rr[k] : -1;
      checks++; if (gi != 91 + 80 * k || gr != 80) begin errors++; $display("FAIL spikes_beat%0d: got idx %0d rr %0d expected idx %0d rr 80", k, gi, gr, 91 + 80 * k); end
    end
    checks++; if (dut.spk_q !== 16'd408) begin errors++; $display("FAIL spikes_spk: got %0d expected 408", dut.spk_q); end
    checks++; if (dut.thresh_q !== 16'd204) begin errors++; $display("FAIL spikes_thresh: got %0d expected 204", dut.thresh_q); end
    checks++; if (to_idx.size() != 0) begin errors++; $display("FAIL spikes_no_timeout: got %0d expected 0", to_idx.size()); end
  endtask

  task automatic test_refractory();
    int gi, gr;
    do_reset();
    fill(250, 12'sd0);
    stim[9] = 12'sd800; stim[89] = 12'sd800; stim[99] = 12'sd800; stim[169] = 12'sd800;
    play();
    checks++; if (pk_idx.size() != 2) begin errors++; $display("FAIL refract_count: got %0d expected 2", pk_idx.size()); end
    for (int k = 0; k < 2; k++) begin
      gi = (k < pk_idx.size()) ? pk_idx[k] : -1;
      gr = (k < pk_rr.size()) ? pk_rr[k] : -1;
      checks++; if (gi != 91 + 80 * k || gr != 80) begin errors++; $display("FAIL refract_beat%0d: got idx %0d rr %0d expected idx %0d rr 80", k, gi, gr, 91 + 80 * k); end
    end
    checks++; if (dut.thresh_q !== 16'd175) begin errors++; $display("FAIL refract_thresh: got %0d expected 175", dut.thresh_q); end
  endtask

  task automatic test_forced_confirm();
    int gi, gr;
    do_reset();
    fill(120, 12'sd0);
    stim[9] = 12'sd800;
    for (int k = 0; k < 15; k++) stim[49 + k] = 12'(100 * (k + 1));
    for (int i = 64; i < 120; i++) stim[i] = 12'sd1500;
    play();
    gi = (pk_idx.size() > 0) ? pk_idx[0] : -1;
    gr = (pk_rr.size() > 0) ? pk_rr[0] : -1;
    checks++; if (pk_idx.size() != 1 || gi != 61 || gr != 50) begin errors++; $display("FAIL ramp_forced: got %0d pulses idx %0d rr %0d expected 1 idx 61 rr 50", pk_idx.size(), gi, gr); end
    checks++; if (dut.thresh_q !== 16'd105) begin errors++; $display("FAIL ramp_thresh: got %0d expected 105", dut.thresh_q); end
  endtask

  task automatic test_reset_mid_track();
    int gi, gr;
    do_reset();
    fill(170, 12'sd0);
    stim[9] = 12'sd800; stim[89] = 12'sd800; stim[169] = 12'sd800;
    play();
    checks++; if (pk_idx.size() != 1 || bus.rr_value !== 16'd80) begin errors++; $display("FAIL pre_reset_beat: got %0d pulses rr %0d expected 1 rr 80", pk_idx.size(), bus.rr_value); end
    checks++; if (int'(dut.state_q) != 1) begin errors++; $display("FAIL pre_reset_tracking: got state %0d expected 1", int'(dut.state_q)); end
    do_reset();
    checks++; if (bus.rr_value !== 16'd0 || bus.r_peak !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got rr %0d r_peak %0d expected 0 0", bus.rr_value, bus.r_peak); end
    checks++; if (dut.thresh_q !== 16'd64) begin errors++; $display("FAIL mid_reset_thresh: got %0d expected 64", dut.thresh_q); end
    fill(170, 12'sd0);
    stim[4] = 12'sd800; stim[79] = 12'sd800; stim[154] = 12'sd800;
    play();
    checks++; if (pk_idx.size() != 2) begin errors++; $display("FAIL post_reset_count: got %0d expected 2", pk_idx.size()); end
    for (int k = 0; k < 2; k++) begin
      gi = (k < pk_idx.size()) ? pk_idx[k] : -1;
      gr = (k < pk_rr.size()) ? pk_rr[k] : -1;
      checks++; if (gi != 81 + 75 * k || gr != 75) begin errors++; $display("FAIL post_reset_beat%0d: got idx %0d rr %0d expected idx %0d rr 75", k, gi, gr, 81 + 75 * k); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    fill(91, 12'sd0);
    stim[9] = 12'sd800; stim[89] = 12'sd800;
    play();
    bus.ecg_sample = -12'sd1234;
    repeat (50) @(negedge clk);
    checks++; if (bus.r_peak !== 1'b1 || bus.rr_value !== 16'd80) begin errors++; $display("FAIL hold_beat: got r_peak %0d rr %0d expected 1 80", bus.r_peak, bus.rr_value); end
    checks++; if (dut.since_q !== 16'd1 || dut.thresh_q !== 16'd143) begin errors++; $display("FAIL hold_state: got since %0d thresh %0d expected 1 143", dut.since_q, dut.thresh_q); end
    smp(12'sd0);
    checks++; if (bus.r_peak !== 1'b0 || bus.rr_value !== 16'd80) begin errors++; $display("FAIL beat_one_period: got r_peak %0d rr %0d expected 0 80", bus.r_peak, bus.rr_value); end
  endtask

  task automatic test_saturation();
    do_reset();
    fill(12, 12'sd0);
    for (int i = 0; i < 12; i++) stim[i] = ((i / 2) % 2 == 0) ? -12'sd2048 : 12'sd2047;
    play();
    checks++; if (pk_idx.size() != 0) begin errors++; $display("FAIL sat_first_beat_silent: got %0d pulses expected 0", pk_idx.size()); end
    checks++; if (int'(dut.state_q) != 2) begin errors++; $display("FAIL sat_confirmed: got state %0d expected 2", int'(dut.state_q)); end
    checks++; if (dut.spk_q !== 16'd623 || dut.thresh_q !== 16'd311) begin errors++; $display("FAIL sat_energy: got spk %0d thresh %0d expected 623 311", dut.spk_q, dut.thresh_q); end
  endtask

  task automatic test_timeout_confirm();
    do_reset();
    fill(400, 12'sd0);
    stim[298] = 12'sd800;
    play();
    checks++; if (to_idx.size() != 0 || pk_idx.size() != 0) begin errors++; $display("FAIL collide_events: got %0d timeouts %0d peaks expected 0 0", to_idx.size(), pk_idx.size()); end
    checks++; if (dut.thresh_q !== 16'd106) begin errors++; $display("FAIL collide_thresh: got %0d expected 106", dut.thresh_q); end
    checks++; if (dut.since_q !== 16'd101) begin errors++; $display("FAIL collide_since_last: got %0d expected 101", dut.since_q); end
  endtask

  initial begin
    bus.sample_en  = 1'b0;
    bus.ecg_sample = '0;
    test_reset();
    test_timeout();
    test_spikes();
    test_refractory();
    test_forced_confirm();
    test_reset_mid_track();
    test_hold();
    test_saturation();
    test_timeout_confirm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_interval_extractor.md
Name: rr_interval_extractor

Overview:
- Upstream stage of the apnea detector. Consumes raw ECG samples at the 100 Hz sample_en rate and detects R-peaks using a slope-energy measure with an adaptive threshold.
- Produces the r_peak pulse and the rr_value (beat-to-beat interval, in samples) that the apnea window-statistics stage accumulates.
- Includes refractory blanking, a no-beat timeout with threshold search-back, and suppression of the first, interval-less beat after reset.

Parameters:
- DATA_W, 12, ECG sample width (signed two's complement).
- REFRACTORY, 20, samples blanked after a confirmed peak (200 ms).
- MAX_TRACK, 10, max samples spent tracking one peak before forced confirm.
- RR_TIMEOUT, 300, samples without a peak before search-back (3 s).
- INIT_THRESH, 64, threshold loaded at reset.
- MIN_THRESH, 8, floor for threshold.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-clk 100 Hz sample strobe; all state advances only when high.
- ecg_sample  in  DATA_W  signed ECG sample, valid when sample_en=1.
- r_peak  out  1  high for exactly one sample period per reported beat.
- rr_value  out  16  interval since previous confirmed peak, in samples.
- peak_timeout  out  1  high for one sample period when RR_TIMEOUT expires.

Behaviour:
- Reset (rst_n=0, async): r_peak=0, rr_value=0, peak_timeout=0, thresh=INIT_THRESH, spk=2*INIT_THRESH, state=SEARCH, armed=0, x1=x2=0, all counters 0.
- Slope energy, per sample_en: d = ecg_sample - x2, computed in DATA_W+1 signed bits. e = |d| as DATA_W unsigned, saturating at 2^DATA_W-1 (the d = -2^DATA_W case). Then x2<=x1, x1<=ecg_sample.
- Interval counter since_last: +1 per sample_en, saturating at 16'hFFFF. On a confirm sample it loads 1.
- FSM, evaluated only on sample_en:
  - SEARCH: if e > thresh, go to TRACK with pk=e, trk=1.
  - TRACK: if e >= pk, pk<=e. Otherwise, if e < (pk>>1), confirm. Also confirm if trk == MAX_TRACK. Else trk+1.
  - REFRACT: rcnt counts to REFRACTORY, then go to SEARCH. Input is ignored for detection but still shifts x1/x2.
- Confirm actions, all on the same sample_en edge:
  - state<=REFRACT, rcnt<=1.
  - spk <= spk - (spk>>3) + (pk>>3).
  - thresh <= max(spk_new>>1, MIN_THRESH).
  - If armed=1: rr_value<=since_last (pre-reload value) and r_peak<=1. If armed=0: armed<=1 and no pulse.
- r_peak/peak_timeout timing:
  - Set on the sample_en edge that raises the event; cleared on the next sample_en edge.
  - Each is therefore high during exactly one subsequent sample_en cycle, which the downstream stage samples.
  - rr_value changes only on confirm and is stable while r_peak is high and until the next confirm.
- Timeout: in SEARCH or TRACK, when since_last reaches RR_TIMEOUT:
  - peak_timeout pulses and thresh <= max(thresh>>1, MIN_THRESH).
  - since_last keeps counting; further halvings occur every RR_TIMEOUT samples (since_last mod RR_TIMEOUT == 0).
  - Timeout is not checked in REFRACT.
- Simultaneous timeout and confirm: confirm wins; no peak_timeout, no halving.
- sample_en=0: all registers hold.
- Reset mid-TRACK: pending peak discarded, armed=0; the next beat only re-arms.
- Latency: r_peak rises 1 clk after the confirm sample_en edge; the confirm sample is 1–MAX_TRACK samples after the threshold crossing.

Test Plan:
- Reset, then flat ecg_sample=0 for 400 samples -> no r_peak; peak_timeout pulses at since_last=300; thresh 64->32.
- Spikes of +800 (one sample, else 0) every 80 samples -> first spike r_peak=0 (arm only); each later one gives r_peak=1 for one sample period with rr_value=80; spk/thresh converge upward.
- Two spikes 10 samples apart (inside REFRACTORY=20) after arming -> second ignored; next spike at +80 from first reports rr_value=80.
- Slow ramp held above thresh for 15 samples -> forced confirm at trk=10, single r_peak.
- Assert rst_n=0 mid-TRACK, release, send spikes every 75 -> first post-reset spike silent, next gives rr_value=75.
- ecg_sample alternating -2048/+2047 -> e saturates at 4095, no overflow; with sample_en held low 50 clks, outputs and counters unchanged.
